// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory with a one-cycle registered read.
// Port A is the CPU MEM stage and port B is the loader/debug master; only one access is in flight at a time.
module data_mem_arbiter #(
  parameter int DATA_BITS  = 64,
  parameter int ADDR_BITS  = 10,
  parameter int FIXED_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_wr,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [DATA_BITS-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_done,
  output logic [DATA_BITS-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_wr,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [DATA_BITS-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_done,
  output logic [DATA_BITS-1:0] b_rdata,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_d_in,
  input  logic [DATA_BITS-1:0] mem_d_out,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  // Handshake: a requester holds req (and keeps wr/addr/wdata stable) until it
  // sees gnt, then drops req the next cycle. gnt and done are one-cycle pulses
  // decoded from registered state, so nothing combinational runs from req to outputs.

  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_owner_q, last_owner_d;
  logic                 cmd_wr_q, cmd_wr_d;
  logic [ADDR_BITS-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_BITS-1:0] cmd_wdata_q, cmd_wdata_d;

  logic arb_last;
  logic win_b;
  logic load;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cmd_wr_d     = cmd_wr_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    load         = 1'b0;

    // In RESP the access now finishing counts as the most recent owner.
    arb_last = (state_q == RESP) ? owner_q : last_owner_q;
    if (a_req && b_req) begin
      win_b = (FIXED_PRIO != 0) ? 1'b0 : (arb_last == OWN_A);
    end else begin
      win_b = b_req;
    end

    case (state_q)
      IDLE: begin
        if (a_req || b_req) load = 1'b1;
      end
      CMD: begin
        state_d = RESP;
      end
      RESP: begin
        last_owner_d = owner_q;
        if (a_req || b_req) load = 1'b1;
        else state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d     = CMD;
      owner_d     = win_b ? OWN_B : OWN_A;
      cmd_wr_d    = win_b ? b_wr    : a_wr;
      cmd_addr_d  = win_b ? b_addr  : a_addr;
      cmd_wdata_d = win_b ? b_wdata : a_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_A;
      last_owner_q <= OWN_B;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
    end
  end

  assign mem_en    = (state_q == CMD);
  assign mem_wr    = (state_q == CMD) && cmd_wr_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_d_in  = cmd_wdata_q;

  assign a_gnt     = (state_q == CMD)  && (owner_q == OWN_A);
  assign b_gnt     = (state_q == CMD)  && (owner_q == OWN_B);
  assign a_done    = (state_q == RESP) && (owner_q == OWN_A);
  assign b_done    = (state_q == RESP) && (owner_q == OWN_B);
  assign a_rdata   = a_done ? mem_d_out : '0;
  assign b_rdata   = b_done ? mem_d_out : '0;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a round-robin instance and a fixed-priority
// instance share stimulus, each with its own single-port memory model.
module tb_data_mem_arbiter;

  localparam int DW = 64;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;

  logic          a_gnt, a_done, b_gnt, b_done, mem_en, mem_wr;
  logic [DW-1:0] a_rdata, b_rdata, mem_d_in, mem_d_out;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  logic          a_gnt_p, a_done_p, b_gnt_p, b_done_p, mem_en_p, mem_wr_p;
  logic [DW-1:0] a_rdata_p, b_rdata_p, mem_d_in_p, mem_d_out_p;
  logic [AW-1:0] mem_addr_p;
  logic [1:0]    dbg_state_p;

  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic          init_done = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_p_q[$];

  always #5 clk = ~clk;

  data_mem_arbiter #(.DATA_BITS(DW), .ADDR_BITS(AW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_d_in(mem_d_in),
    .mem_d_out(mem_d_out), .dbg_state(dbg_state)
  );

  data_mem_arbiter #(.DATA_BITS(DW), .ADDR_BITS(AW), .FIXED_PRIO(1)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_p), .a_done(a_done_p), .a_rdata(a_rdata_p),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_p), .b_done(b_done_p), .b_rdata(b_rdata_p),
    .mem_en(mem_en_p), .mem_wr(mem_wr_p), .mem_addr(mem_addr_p), .mem_d_in(mem_d_in_p),
    .mem_d_out(mem_d_out_p), .dbg_state(dbg_state_p)
  );

  // Memory models: a write echoes its data on d_out; preload happens on the first edge.
  always @(posedge clk) begin
    if (!init_done) begin
      mem0[5]   <= 64'hDEAD_BEEF_0000_0005;
      mem1[5]   <= 64'hDEAD_BEEF_0000_0005;
      mem0[7]   <= 64'h7777;
      mem1[7]   <= 64'h7777;
      mem0[3]   <= 64'h0;
      mem1[3]   <= 64'h0;
      init_done <= 1'b1;
    end else begin
      if (mem_en) begin
        if (mem_wr) mem0[mem_addr] <= mem_d_in;
        mem_d_out <= mem_wr ? mem_d_in : mem0[mem_addr];
      end
      if (mem_en_p) begin
        if (mem_wr_p) mem1[mem_addr_p] <= mem_d_in_p;
        mem_d_out_p <= mem_wr_p ? mem_d_in_p : mem1[mem_addr_p];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #3;
    chk_cnt++; if ({mem_en, mem_wr} !== 2'b00) $display("FAIL reset_mem_en_wr: got %b exp 00", {mem_en, mem_wr}); else pass_cnt++;
    chk_cnt++; if ({a_gnt, b_gnt, a_done, b_done} !== 4'b0000) $display("FAIL reset_gnt_done: got %b exp 0000", {a_gnt, b_gnt, a_done, b_done}); else pass_cnt++;
    chk_cnt++; if (a_rdata !== '0 || b_rdata !== '0) $display("FAIL reset_rdata: got %h/%h exp 0/0", a_rdata, b_rdata); else pass_cnt++;
    chk_cnt++; if (mem_addr !== '0 || mem_d_in !== '0) $display("FAIL reset_mem_bus: got %h/%h exp 0/0", mem_addr, mem_d_in); else pass_cnt++;
    chk_cnt++; if (dbg_state !== 2'd0 || dbg_state_p !== 2'd0) $display("FAIL reset_state: got %0d/%0d exp 0/0", dbg_state, dbg_state_p); else pass_cnt++;
    apply_reset();
  endtask

  task automatic test_single_read_a();
    a_req = 1'b1; a_wr = 1'b0; a_addr = 10'd5;
    step();
    chk_cnt++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) $display("FAIL rd_a_gnt: got %b%b exp 10", a_gnt, b_gnt); else pass_cnt++;
    chk_cnt++; if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 10'd5) $display("FAIL rd_a_cmd: got en=%b wr=%b addr=%0d exp en=1 wr=0 addr=5", mem_en, mem_wr, mem_addr); else pass_cnt++;
    a_req = 1'b0;
    step();
    chk_cnt++; if (a_done !== 1'b1 || mem_en !== 1'b0) $display("FAIL rd_a_done: got done=%b en=%b exp done=1 en=0", a_done, mem_en); else pass_cnt++;
    chk_cnt++; if (a_rdata !== 64'hDEAD_BEEF_0000_0005) $display("FAIL rd_a_data: got %h exp deadbeef00000005", a_rdata); else pass_cnt++;
    chk_cnt++; if (b_done !== 1'b0 || b_rdata !== '0) $display("FAIL rd_a_b_idle: got done=%b rdata=%h exp 0/0", b_done, b_rdata); else pass_cnt++;
    step();
    chk_cnt++; if (a_done !== 1'b0 || a_rdata !== '0 || dbg_state !== 2'd0) $display("FAIL rd_a_after: got done=%b rdata=%h st=%0d exp 0/0/0", a_done, a_rdata, dbg_state); else pass_cnt++;
  endtask

  task automatic test_write_read_b();
    b_req = 1'b1; b_wr = 1'b1; b_addr = 10'd3; b_wdata = 64'h1234;
    step();
    chk_cnt++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) $display("FAIL wr_b_gnt: got a=%b b=%b exp a=0 b=1", a_gnt, b_gnt); else pass_cnt++;
    chk_cnt++; if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 10'd3 || mem_d_in !== 64'h1234) $display("FAIL wr_b_cmd: got en=%b wr=%b addr=%0d d=%h exp 1 1 3 1234", mem_en, mem_wr, mem_addr, mem_d_in); else pass_cnt++;
    b_req = 1'b0;
    step();
    chk_cnt++; if (b_done !== 1'b1 || b_rdata !== 64'h1234 || mem_wr !== 1'b0) $display("FAIL wr_b_done: got done=%b rdata=%h wr=%b exp 1 1234 0", b_done, b_rdata, mem_wr); else pass_cnt++;
    b_req = 1'b1; b_wr = 1'b0;
    step();
    chk_cnt++; if (b_gnt !== 1'b1 || mem_en !== 1'b1 || mem_wr !== 1'b0) $display("FAIL rd_b_cmd: got gnt=%b en=%b wr=%b exp 1 1 0", b_gnt, mem_en, mem_wr); else pass_cnt++;
    chk_cnt++; if (mem0[3] !== 64'h1234) $display("FAIL wr_b_mem: got %h exp 1234", mem0[3]); else pass_cnt++;
    b_req = 1'b0;
    step();
    chk_cnt++; if (b_done !== 1'b1 || b_rdata !== 64'h1234) $display("FAIL rd_b_done: got done=%b rdata=%h exp 1 1234", b_done, b_rdata); else pass_cnt++;
    step();
    chk_cnt++; if (mem_en !== 1'b0 || mem_addr !== 10'd3 || b_rdata !== '0) $display("FAIL rd_b_idle_hold: got en=%b addr=%0d rdata=%h exp 0 3 0", mem_en, mem_addr, b_rdata); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    a_req = 1'b1; a_wr = 1'b0; a_addr = 10'd5;
    step();
    chk_cnt++; if (a_gnt !== 1'b1) $display("FAIL b2b_a_gnt: got %b exp 1", a_gnt); else pass_cnt++;
    a_req = 1'b0;
    step();
    chk_cnt++; if (a_done !== 1'b1 || a_rdata !== 64'hDEAD_BEEF_0000_0005) $display("FAIL b2b_a_done: got done=%b rdata=%h exp 1 deadbeef00000005", a_done, a_rdata); else pass_cnt++;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 10'd3;
    step();
    chk_cnt++; if (b_gnt !== 1'b1 || dbg_state !== 2'd1 || a_done !== 1'b0) $display("FAIL b2b_b_gnt: got gnt=%b st=%0d a_done=%b exp 1 1 0", b_gnt, dbg_state, a_done); else pass_cnt++;
    b_req = 1'b0;
    step();
    chk_cnt++; if (b_done !== 1'b1 || b_rdata !== 64'h1234) $display("FAIL b2b_b_done: got done=%b rdata=%h exp 1 1234", b_done, b_rdata); else pass_cnt++;
    step();
  endtask

  task automatic test_simultaneous();
    logic [1:0] e, ep;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
      exp_q.push_back(2'b00);
      exp_p_q.push_back(2'b10);
      exp_p_q.push_back(2'b00);
    end
    a_req = 1'b1; a_wr = 1'b0; a_addr = 10'd5;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 10'd3;
    for (int c = 0; c < 8; c++) begin
      step();
      e  = exp_q.pop_front();
      ep = exp_p_q.pop_front();
      chk_cnt++; if ({a_gnt, b_gnt} !== e) $display("FAIL rr_gnt cycle %0d: got %b exp %b", c, {a_gnt, b_gnt}, e); else pass_cnt++;
      chk_cnt++; if ({a_gnt_p, b_gnt_p} !== ep) $display("FAIL prio_gnt cycle %0d: got %b exp %b", c, {a_gnt_p, b_gnt_p}, ep); else pass_cnt++;
    end
    a_req = 1'b0; b_req = 1'b0;
    step();
    chk_cnt++; if (dbg_state !== 2'd0 || dbg_state_p !== 2'd0) $display("FAIL sim_idle: got %0d/%0d exp 0/0", dbg_state, dbg_state_p); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    a_req = 1'b1; a_wr = 1'b1; a_addr = 10'd7; a_wdata = 64'hFF;
    step();
    chk_cnt++; if (mem_en !== 1'b1 || mem_wr !== 1'b1 || a_gnt !== 1'b1) $display("FAIL rst_wr_cmd: got en=%b wr=%b gnt=%b exp 1 1 1", mem_en, mem_wr, a_gnt); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (mem_en !== 1'b0 || mem_wr !== 1'b0 || a_gnt !== 1'b0) $display("FAIL rst_wr_drop: got en=%b wr=%b gnt=%b exp 0 0 0", mem_en, mem_wr, a_gnt); else pass_cnt++;
    chk_cnt++; if (mem_addr !== '0 || mem_d_in !== '0 || dbg_state !== 2'd0) $display("FAIL rst_wr_regs: got addr=%h d=%h st=%0d exp 0 0 0", mem_addr, mem_d_in, dbg_state); else pass_cnt++;
    a_req = 1'b0;
    step();
    chk_cnt++; if (mem0[7] !== 64'h7777) $display("FAIL rst_wr_mem: got %h exp 7777", mem0[7]); else pass_cnt++;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk_cnt++; if (a_done !== 1'b0 || a_rdata !== '0 || dbg_state !== 2'd0) $display("FAIL rst_wr_nodone %0d: got done=%b rdata=%h st=%0d exp 0 0 0", c, a_done, a_rdata, dbg_state); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_read_a();
    test_write_read_b();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory (en/wr/addr/d_in, one-cycle registered d_out) between two requesters.
- Port A is the CPU MEM stage; port B is the loader/debug master.
- Registers one command per access, drives the memory enables, and returns read data with a done pulse.
- One access in flight at a time. Round-robin or fixed-priority arbitration.

Parameters:
- DATA_BITS, 64, width of the data words.
- ADDR_BITS, 10, width of the word address presented to the memory.
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins when both request.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A request; held high until a_gnt.
- a_wr  input  1  port A write (1) / read (0), valid with a_req.
- a_addr  input  ADDR_BITS  port A address.
- a_wdata  input  DATA_BITS  port A write data.
- a_gnt  output  1  port A command accepted (one-cycle pulse).
- a_done  output  1  port A access complete (one-cycle pulse).
- a_rdata  output  DATA_BITS  port A read data, valid when a_done.
- b_req, b_wr, b_addr, b_wdata, b_gnt, b_done, b_rdata: same as port A, for port B.
- mem_en  output  1  memory enable.
- mem_wr  output  1  memory write.
- mem_addr  output  ADDR_BITS  memory address.
- mem_d_in  output  DATA_BITS  memory write data.
- mem_d_out  input  DATA_BITS  memory output; updates on the edge that samples mem_en=1.

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active-low. Both are fixed.
- FSM states: IDLE, CMD, RESP. Registers: state, owner (A/B), last_owner, cmd_wr, cmd_addr, cmd_wdata.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner, latch its wr/addr/wdata into the cmd registers, set owner, go to CMD.
- CMD:
  - Drive mem_en=1, mem_wr=cmd_wr, mem_addr=cmd_addr, mem_d_in=cmd_wdata.
  - Assert gnt for the owner.
  - Always go to RESP; the memory samples the command at the end of CMD.
- RESP:
  - Assert done for the owner; owner rdata = mem_d_out. For writes, rdata is the written data as echoed by the memory.
  - Set last_owner <= owner.
  - Arbitrate among requests seen this cycle. A winner goes to CMD with its command latched; no request goes to IDLE.
- Requester protocol: the requester drops req in the cycle after gnt. A req still high in RESP is a new request.
- Arbitration with FIXED_PRIO=0:
  - Single requester wins.
  - Tie goes to the port that is not last_owner; last_owner resets to B, so A wins the first tie.
  - In RESP, last_owner is taken as the current owner.
- Arbitration with FIXED_PRIO=1: A wins every tie; B can starve (documented, intended).
- Latency and throughput:
  - gnt 1 cycle after req is first sampled in IDLE; done 2 cycles after req.
  - Sustained throughput is one access per 2 cycles.
- mem_en, mem_wr, gnt and done are decoded from registered state only. No combinational path from req to mem_* or gnt.
- Outside CMD: mem_en=0, mem_wr=0; mem_addr and mem_d_in hold their last value.
- Inactive port: rdata is 0; rdata is non-zero only with done.
- Reset values:
  - state=IDLE, owner=A, last_owner=B.
  - cmd_* = 0, so mem_addr=0 and mem_d_in=0.
  - mem_en=0, mem_wr=0, all gnt/done=0, all rdata=0.
- Reset mid-operation clears immediately and asynchronously:
  - Reset asserted in CMD before the edge: mem_en drops, so no write is committed.
  - Reset in RESP: done is suppressed and the access is abandoned.
- req with X on wr/addr is only sampled in IDLE or RESP; the bench holds the fields stable while req is high.

Test Plan:
- Single read, A:
  - Preload mem[5]=64'hDEAD_BEEF_0000_0005; a_req=1, a_wr=0, a_addr=5.
  - a_gnt in cycle 1, mem_en=1 with mem_addr=5 in the same cycle.
  - a_done in cycle 2 with a_rdata=64'hDEAD_BEEF_0000_0005.
- Write then read, B:
  - b writes 64'h1234 to addr 3, then reads addr 3.
  - b_done on both accesses; read returns 64'h1234.
  - mem_wr=1 only in the write CMD cycle.
- Simultaneous requests, FIXED_PRIO=0:
  - a_req and b_req held high continuously.
  - Grants alternate A, B, A, B, one every 2 cycles; A first after reset.
- Same traffic with FIXED_PRIO=1: A granted every access; b_gnt never asserted while a_req is high.
- Back-to-back from RESP: A read done cycle coincides with b_req=1 -> b_gnt in the next cycle, no IDLE cycle in between.
- Reset mid-write: rst_n low during CMD of A write 64'hFF to addr 7 -> mem_en=0 immediately, no a_done, mem[7] unchanged, all outputs at reset values.
